// File: rtl/pipelined_adder_pkg.sv
// ---------------------------------------------------------------------------
// pipelined_adder_pkg
//   Shared types and constants for the pipelined add/subtract unit.
//   - DATA_W    : widest operand the stage record can carry
//   - MAX_POS / MIN_NEG : saturation limits at DATA_W. The top shifts them
//                         down to its own WIDTH.
//   - stage_t   : one pipeline register slot
//   - slice_width() : chunk width handled by each stage
// ---------------------------------------------------------------------------
package pipelined_adder_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    // a_rem/b_rem carry the operands forward. b_rem is already conditionally
    // inverted for subtraction. psum accumulates finished chunks from the LSB
    // upward. cin is the carry into the next chunk.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] a_rem;
        logic [DATA_W-1:0] b_rem;
        logic [DATA_W-1:0] psum;
        logic              cin;
        logic              sub;
    } stage_t;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipelined_adder_add_slice.sv
// ---------------------------------------------------------------------------
// add_slice
//   Combinational CW-bit adder slice.
//   Ports:
//     a, b    : slice operands (b already inverted for subtraction)
//     cin     : carry into bit 0 of the slice
//     s       : slice sum
//     cout    : carry out of the slice MSB
//     msb_cin : carry into the slice MSB (used for signed overflow)
// ---------------------------------------------------------------------------
module add_slice #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout,
    output logic          msb_cin
);

    logic [CW:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    assign s    = full[CW-1:0];
    assign cout = full[CW];

    // The sum bit equals a ^ b ^ carry_in. The carry into the MSB can
    // therefore be recovered from the MSB sum bit.
    assign msb_cin = a[CW-1] ^ b[CW-1] ^ s[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//   Pipelined WIDTH-bit add/subtract unit. The add is split into STAGES
//   chunks of CW = WIDTH/STAGES bits, and the carry is registered between
//   chunks. Latency is STAGES cycles. The final stage register is the
//   output register.
//
//   Parameters: WIDTH (<= DATA_W, divisible by STAGES), STAGES (1..WIDTH)
//   Ports:
//     clk, rst           : clock, synchronous active-high reset
//     in_valid/in_ready  : operand handshake (a, b, sub)
//     out_valid/out_ready: result handshake (sum, carry, overflow, zero)
//     sub                : 0 = a+b, 1 = a-b (a + ~b + 1)
//     carry              : carry-out of the MSB (for sub, 1 = no borrow)
//     overflow           : signed two's-complement overflow
//     zero               : sum == 0
//   Configuration macro: PIPELINED_ADDER_SAT_EN
//     Defined     : sum clamps to MAX_POS/MIN_NEG on signed overflow.
//     Not defined : sum wraps.
//
//   Handshake: a beat moves on a cycle where valid && ready. A global stall
//   (out_valid && !out_ready) freezes every stage, and in_ready drops
//   combinationally in that cycle. Bubbles travel with the pipeline and are
//   never squeezed out.
// ---------------------------------------------------------------------------
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int CW   = slice_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    stage_t st  [STAGES];   // pipeline registers
    stage_t src [STAGES];   // what each stage consumes this cycle
    stage_t nxt [STAGES];   // what each stage will register

    logic [STAGES-1:0][CW-1:0] sl_a;
    logic [STAGES-1:0][CW-1:0] sl_b;
    logic [STAGES-1:0][CW-1:0] sl_s;
    logic [STAGES-1:0]         sl_ci;
    logic [STAGES-1:0]         sl_co;
    logic [STAGES-1:0]         sl_mci;

    logic             stall;
    logic             fin_ovf;
    logic             fin_zero;
    logic [WIDTH-1:0] fin_sum;
    logic             ovf_q;
    logic             zero_q;
    logic             unused_bits;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Stage 0 takes the raw operands. The inversion for subtraction happens
    // once here, and sub is injected as the initial carry.
    always_comb begin
        src[0]       = '0;
        src[0].valid = in_valid;
        src[0].a_rem = DATA_W'(a);
        src[0].b_rem = DATA_W'(b ^ {WIDTH{sub}});
        src[0].cin   = sub;
        src[0].sub   = sub;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = st[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        assign sl_a[k]  = src[k].a_rem[k*CW +: CW];
        assign sl_b[k]  = src[k].b_rem[k*CW +: CW];
        assign sl_ci[k] = src[k].cin;

        add_slice #(.CW(CW)) u_slice (
            .a       (sl_a[k]),
            .b       (sl_b[k]),
            .cin     (sl_ci[k]),
            .s       (sl_s[k]),
            .cout    (sl_co[k]),
            .msb_cin (sl_mci[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt[k]                  = src[k];
            nxt[k].psum[k*CW +: CW] = sl_s[k];
            nxt[k].cin              = sl_co[k];
        end

        // Both flags come from the same top slice: overflow is when the
        // carry into the MSB differs from the carry out of the MSB.
        fin_ovf = sl_mci[LAST] ^ sl_co[LAST];
        fin_sum = nxt[LAST].psum[WIDTH-1:0];
`ifdef PIPELINED_ADDER_SAT_EN
        // Overflow only happens when both operands share a sign. The sign of
        // a then tells whether the result overflowed upward or downward.
        if (fin_ovf) begin
            fin_sum = sl_a[LAST][CW-1] ? WIDTH'(MIN_NEG >> (DATA_W - WIDTH))
                                       : WIDTH'(MAX_POS >> (DATA_W - WIDTH));
        end
`endif
        nxt[LAST].psum = DATA_W'(fin_sum);
        fin_zero       = (fin_sum == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                st[k] <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                st[k] <= nxt[k];
            end
            ovf_q  <= fin_ovf;
            zero_q <= fin_zero;
        end
    end

    assign out_valid = st[LAST].valid;
    assign sum       = st[LAST].psum[WIDTH-1:0];
    assign carry     = st[LAST].cin;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

    // Some fields are not read downstream: the consumed operand chunks, the
    // tracked sub bit, and the MSB carry taps of the lower slices.
    always_comb begin
        unused_bits = ^sl_mci;
        for (int k = 0; k < STAGES; k++) begin
            unused_bits = unused_bits ^ (^st[k]);
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
`ifdef PIPELINED_ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  sum;
    logic              carry;
    logic              overflow;
    logic              zero;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_out    = 0;
    bit chk_lat  = 1'b1;

    // {carry, overflow, zero, sum}
    logic [WIDTH+2:0] exp_q[$];
    int               acc_q[$];
    logic [WIDTH+2:0] mon_e;
    int               mon_t;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Reference model: signed/unsigned integer arithmetic on wide values
    function automatic logic [WIDTH+2:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint          sx, sy, r;
        longint unsigned ux, uy;
        logic            c, o, z;
        logic [31:0]     res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        if (s) begin
            r = sx - sy;
            c = (ux >= uy);
        end else begin
            r = sx + sy;
            c = ((ux + uy) > 64'hFFFF_FFFF);
        end
        o   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        res = r[31:0];
        if (SAT && o) res = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        z = (res == 32'd0);
        return {c, o, z, res};
    endfunction

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("out_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    mon_t = acc_q.pop_front();
                    check("model_sum", sum, mon_e[31:0]);
                    check("model_flags", {carry, overflow, zero}, mon_e[34:32]);
                    if (chk_lat) check("latency", 64'(cyc - mon_t), 64'(STAGES));
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, sub));
                acc_q.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic xs);
        int g;
        g = 0;
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        sub      = xs;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            g++;
            @(negedge clk);
        end
        check("send_accepted", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input logic [31:0] es,
                            input logic ec, input logic eo, input logic ez);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!out_valid && g < 50);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_sum"}, sum, es);
        check({name, "_flags"}, {carry, overflow, zero}, {ec, eo, ez});
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int base;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sum", sum, 0);
        check("rst_flags", {carry, overflow, zero}, 3'b000);
        @(posedge clk);
        #1;

        // 1: simple add
        send(32'h1, 32'h2, 1'b0);
        wait_out("t1", 32'h3, 1'b0, 1'b0, 1'b0);

        // 2: positive signed overflow
        send(32'h7FFF_FFFF, 32'h1, 1'b0);
        wait_out("t2", SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        // 3: unsigned wrap to zero, then subtract to zero
        send(32'hFFFF_FFFF, 32'h1, 1'b0);
        send(32'h5, 32'h5, 1'b1);
        wait_out("t3a", 32'h0, 1'b1, 1'b0, 1'b1);
        wait_out("t3b", 32'h0, 1'b1, 1'b0, 1'b1);

        // 4: negative signed overflow
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_out("t4", SAT ? 32'h8000_0000 : 32'h0, 1'b1, 1'b1, SAT ? 1'b0 : 1'b1);

        // extra subtracts: borrow, and negative overflow on subtract
        send(32'h3, 32'h5, 1'b1);
        wait_out("t_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h1, 1'b1);
        wait_out("t_subovf", SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // 5: back-to-back with a 3-cycle downstream stall
        chk_lat = 1'b0;
        base    = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send(32'(i), 32'(i), 1'b0);
            end
            begin
                int g;
                g = 0;
                do begin
                    @(posedge clk);
                    #1;
                    g++;
                end while (!out_valid && g < 50);
                check("t5_first_valid", out_valid, 1);
                out_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check("t5_in_ready_stall", in_ready, 0);
                    check("t5_out_held", out_valid, 1);
                    check("t5_sum_held", sum, 32'h0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        check("t5_count", 64'(n_out - base), 64'd8);
        check("t5_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        chk_lat = 1'b1;

        // 6: reset with three beats in flight
        send(32'd10, 32'd20, 1'b0);
        send(32'd30, 32'd40, 1'b0);
        send(32'd50, 32'd60, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_out_valid_after_rst", out_valid, 0);
        check("t6_in_ready_after_rst", in_ready, 1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("t6_no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(32'd100, 32'd23, 1'b0);
        wait_out("t6_after", 32'd123, 1'b0, 1'b0, 1'b0);

        repeat (6) @(negedge clk);
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
